// File: rtl/counter_seq_ctrl_nbit.sv
// Run sequencer for an n-bit up/down loadable counter: preload, count, pulse done at the end value.
// Build option COUNTER_SEQ_HOLD_EN: while idle, keep the counter loaded with the last end value.
module counter_seq_ctrl_nbit #(
  parameter int CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] start_val,
  input  logic [CNT_WIDTH-1:0] end_val,
  input  logic                 dir,
  input  logic [CNT_WIDTH-1:0] counter_out,
  output logic                 load_en,
  output logic [CNT_WIDTH-1:0] counter_in,
  output logic                 up_down,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

`ifdef COUNTER_SEQ_HOLD_EN
  localparam logic IDLE_LOAD_EN = 1'b1;
`else
  localparam logic IDLE_LOAD_EN = 1'b0;
`endif

  // Even parity over the captured run configuration.
  function automatic logic cfg_parity(
    input logic [CNT_WIDTH-1:0] s_val,
    input logic [CNT_WIDTH-1:0] e_val,
    input logic                 d_val
  );
    return ^{s_val, e_val, d_val};
  endfunction

  state_t               state_r;
  logic [CNT_WIDTH-1:0] start_r;
  logic [CNT_WIDTH-1:0] end_r;
  logic                 dir_r;
  logic                 cfg_par_r;

  logic                 cfg_ok_s;
  logic                 match_s;
  logic                 stop_s;
  logic [CNT_WIDTH-1:0] idle_counter_in_s;

  // Run-termination conditions; a corrupted configuration is treated like abort.
  always_comb begin
    cfg_ok_s = (cfg_parity(start_r, end_r, dir_r) == cfg_par_r);
    match_s  = (counter_out == end_r);
    stop_s   = abort | ~cfg_ok_s;
  end

  // Value presented on counter_in while idle.
  always_comb begin
`ifdef COUNTER_SEQ_HOLD_EN
    idle_counter_in_s = end_r;
`else
    idle_counter_in_s = counter_in;
`endif
  end

  // Sequencer state machine with registered counter controls and status.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      start_r    <= {CNT_WIDTH{1'b0}};
      end_r      <= {CNT_WIDTH{1'b0}};
      dir_r      <= 1'b1;
      cfg_par_r  <= cfg_parity({CNT_WIDTH{1'b0}}, {CNT_WIDTH{1'b0}}, 1'b1);
      load_en    <= IDLE_LOAD_EN;
      counter_in <= {CNT_WIDTH{1'b0}};
      up_down    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && !abort) begin
            start_r    <= start_val;
            end_r      <= end_val;
            dir_r      <= dir;
            cfg_par_r  <= cfg_parity(start_val, end_val, dir);
            state_r    <= LOAD;
            load_en    <= 1'b1;
            counter_in <= start_val;
            up_down    <= dir;
            busy       <= 1'b1;
          end else begin
            state_r    <= IDLE;
            load_en    <= IDLE_LOAD_EN;
            counter_in <= idle_counter_in_s;
            up_down    <= dir_r;
            busy       <= 1'b0;
          end
        end
        LOAD: begin
          if (stop_s) begin
            state_r    <= IDLE;
            load_en    <= IDLE_LOAD_EN;
            counter_in <= idle_counter_in_s;
            busy       <= 1'b0;
          end else begin
            state_r    <= RUN;
            load_en    <= 1'b0;
            busy       <= 1'b1;
          end
          up_down <= dir_r;
        end
        RUN: begin
          // Abort outranks a simultaneous end-value match.
          if (stop_s) begin
            state_r    <= IDLE;
            load_en    <= IDLE_LOAD_EN;
            counter_in <= idle_counter_in_s;
            busy       <= 1'b0;
          end else if (match_s) begin
            state_r    <= IDLE;
            load_en    <= IDLE_LOAD_EN;
            counter_in <= idle_counter_in_s;
            busy       <= 1'b0;
            done       <= 1'b1;
          end else begin
            state_r    <= RUN;
            load_en    <= 1'b0;
            busy       <= 1'b1;
          end
          up_down <= dir_r;
        end
        default: begin
          state_r    <= IDLE;
          load_en    <= IDLE_LOAD_EN;
          counter_in <= idle_counter_in_s;
          up_down    <= dir_r;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule
